// File: rtl/envelope_scheduler_pkg.sv
// Shared types and constants for the envelope scheduler: MCU configuration layout,
// per-oscillator envelope state and the scheduler state encoding.
package envelope_scheduler_pkg;

    localparam int N_OSC   = 4;
    localparam int ENV_LEN = 3;
    localparam int STAGE_W = $clog2(ENV_LEN + 1);
    localparam int IDX_W   = (N_OSC > 1) ? $clog2(N_OSC) : 1;

    localparam logic [31:0] GAIN_MAX = 32'h7FFF_FFFF;

    typedef struct packed {
        logic signed [31:0] rate;
        logic [31:0]        duration;
    } envelope_t;

    typedef struct packed {
        envelope_t [ENV_LEN-1:0] envelopes;
    } wave_gen_t;

    typedef struct packed {
        wave_gen_t [N_OSC-1:0] wave_gens;
    } synth_t;

    typedef struct packed {
        logic [STAGE_W-1:0] stage;
        logic [31:0]        elapsed;
        logic [31:0]        gain;
    } env_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam env_state_t ENV_STATE_RST = '{stage: STAGE_W'(ENV_LEN), elapsed: 32'd0, gain: 32'd0};

    // The sum never exceeds 2*GAIN_MAX, so bit 32 set can only mean a negative result.
    function automatic logic [31:0] sat_gain(input logic signed [32:0] sum);
        if (sum[32])
            return 32'd0;
        else if (sum[31:0] > GAIN_MAX)
            return GAIN_MAX;
        else
            return sum[31:0];
    endfunction

endpackage

// File: rtl/envelope_scheduler_if.sv
// Control, configuration and gain-output bundle between the MCU-side logic and the
// envelope scheduler.
interface envelope_scheduler_if;
    import envelope_scheduler_pkg::*;

    logic                   sample_tick;
    synth_t                 synth;
    logic [N_OSC-1:0]       note_on;
    logic [N_OSC-1:0][31:0] gain;
    logic [N_OSC-1:0]       active;
    logic                   gain_valid;
    logic                   busy;
    logic                   overrun;

    modport slave (
        input  sample_tick, synth, note_on,
        output gain, active, gain_valid, busy, overrun
    );

    modport master (
        output sample_tick, synth, note_on,
        input  gain, active, gain_valid, busy, overrun
    );

endinterface

// File: rtl/envelope_scheduler_step.sv
// Combinational envelope update for one oscillator; shared by all oscillators via
// the scheduler's index mux.
module envelope_step
    import envelope_scheduler_pkg::*;
(
    input  env_state_t              i_state,
    input  logic                    i_pending,
    input  envelope_t [ENV_LEN-1:0] i_envs,
    output env_state_t              o_state
);

    envelope_t          w_env;
    logic signed [32:0] w_sum;
    logic [31:0]        w_elapsed_inc;

    // Compare-select keeps the finished stage value (ENV_LEN) from indexing past the array.
    always_comb begin
        w_env = '0;
        for (int k = 0; k < ENV_LEN; k++) begin
            if (i_state.stage == STAGE_W'(k))
                w_env = i_envs[k];
        end
    end

    assign w_sum         = $signed({1'b0, i_state.gain}) + $signed({w_env.rate[31], w_env.rate});
    assign w_elapsed_inc = i_state.elapsed + 32'd1;

    always_comb begin
        o_state = i_state;
        if (i_pending) begin
            o_state.stage   = '0;
            o_state.elapsed = '0;
            o_state.gain    = '0;
        end else if (i_state.stage != STAGE_W'(ENV_LEN)) begin
            if (w_env.duration == 32'd0) begin
                o_state.stage   = i_state.stage + STAGE_W'(1);
                o_state.elapsed = '0;
            end else begin
                o_state.gain    = sat_gain(w_sum);
                o_state.elapsed = w_elapsed_inc;
                if (w_elapsed_inc == w_env.duration) begin
                    o_state.stage   = i_state.stage + STAGE_W'(1);
                    o_state.elapsed = '0;
                end
            end
        end
    end

endmodule

// File: rtl/envelope_scheduler.sv
// Walks all oscillators through one shared envelope datapath on each sample tick and
// publishes the registered gains with a completion strobe.
//
// state | meaning
// IDLE  | waiting for sample_tick
// RUN   | updating oscillator r_idx this cycle
// DONE  | pass complete, gain_valid high for one cycle
module envelope_scheduler
    import envelope_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    envelope_scheduler_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    env_state_t       r_st [N_OSC];
    logic [N_OSC-1:0] r_pending;
    logic             r_overrun;

    env_state_t              w_cur_state;
    env_state_t              w_next_state;
    logic                    w_cur_pending;
    envelope_t [ENV_LEN-1:0] w_cur_envs;

    assign w_cur_state   = r_st[r_idx];
    assign w_cur_pending = r_pending[r_idx];
    assign w_cur_envs    = bus.synth.wave_gens[r_idx].envelopes;

    envelope_step u_step (
        .i_state   (w_cur_state),
        .i_pending (w_cur_pending),
        .i_envs    (w_cur_envs),
        .o_state   (w_next_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pending <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < N_OSC; i++)
                r_st[i] <= ENV_STATE_RST;
        end else begin
            if (bus.sample_tick && (r_state != ST_IDLE))
                r_overrun <= 1'b1;

            // A note_on landing on the oscillator being processed survives to the next pass.
            for (int i = 0; i < N_OSC; i++) begin
                if (bus.note_on[i])
                    r_pending[i] <= 1'b1;
                else if ((r_state == ST_RUN) && (r_idx == IDX_W'(i)))
                    r_pending[i] <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.sample_tick) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_st[r_idx] <= w_next_state;
                    if (r_idx == IDX_W'(N_OSC - 1))
                        r_state <= ST_DONE;
                    else
                        r_idx <= r_idx + IDX_W'(1);
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_OSC; g++) begin : g_out
        assign bus.gain[g]   = r_st[g].gain;
        assign bus.active[g] = (r_st[g].stage != STAGE_W'(ENV_LEN));
    end

    assign bus.gain_valid = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_envelope_scheduler.sv
// Self-checking bench for envelope_scheduler: directed vector table, hand-written
// timing corner cases and randomized passes against an arithmetic reference model.
module tb_envelope_scheduler;
    import envelope_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    envelope_scheduler_if u_if ();

    envelope_scheduler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_env(input int o, input int s, input logic [31:0] rate, input logic [31:0] dur);
        u_if.synth.wave_gens[o].envelopes[s].rate     = rate;
        u_if.synth.wave_gens[o].envelopes[s].duration = dur;
    endtask

    // Pulse note_on for one idle cycle, then tick; return cycles from tick to gain_valid.
    task automatic run_pass(input logic [N_OSC-1:0] note, output int lat);
        step();
        u_if.note_on = note;
        step();
        u_if.note_on     = '0;
        u_if.sample_tick = 1'b1;
        lat = 0;
        step();
        u_if.sample_tick = 1'b0;
        lat = 1;
        while (!u_if.gain_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    typedef struct packed {
        logic [3:0]       note;
        logic [3:0][31:0] g;
        logic [3:0]       act;
    } vec_t;

    vec_t vecs [10];

    task automatic set_vec(input int k, input logic [3:0] n, input logic [31:0] g0, input logic [31:0] g1,
                           input logic [31:0] g2, input logic [31:0] g3, input logic [3:0] a);
        vecs[k].note = n;
        vecs[k].g[0] = g0;
        vecs[k].g[1] = g1;
        vecs[k].g[2] = g2;
        vecs[k].g[3] = g3;
        vecs[k].act  = a;
    endtask

    longint m_gain  [N_OSC];
    longint m_el    [N_OSC];
    int     m_stage [N_OSC];
    bit     m_pend  [N_OSC];

    task automatic model_reset();
        for (int i = 0; i < N_OSC; i++) begin
            m_gain[i]  = 0;
            m_el[i]    = 0;
            m_stage[i] = ENV_LEN;
            m_pend[i]  = 1'b0;
        end
    endtask

    task automatic model_pass();
        logic signed [31:0] rs;
        longint r, d, s;
        for (int i = 0; i < N_OSC; i++) begin
            if (m_pend[i]) begin
                m_stage[i] = 0;
                m_el[i]    = 0;
                m_gain[i]  = 0;
                m_pend[i]  = 1'b0;
            end else if (m_stage[i] < ENV_LEN) begin
                rs = u_if.synth.wave_gens[i].envelopes[m_stage[i]].rate;
                r  = rs;
                d  = longint'(u_if.synth.wave_gens[i].envelopes[m_stage[i]].duration);
                if (d == 0) begin
                    m_stage[i]++;
                    m_el[i] = 0;
                end else begin
                    s = m_gain[i] + r;
                    if (s < 0) s = 0;
                    if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
                    m_gain[i] = s;
                    m_el[i]++;
                    if (m_el[i] == d) begin
                        m_stage[i]++;
                        m_el[i] = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [3:0] note;
        logic [31:0] rv;

        u_if.sample_tick = 1'b0;
        u_if.note_on     = '0;
        u_if.synth       = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        for (int i = 0; i < N_OSC; i++)
            check($sformatf("rst_gain%0d", i), u_if.gain[i], 32'd0);
        check("rst_active", {28'd0, u_if.active}, 32'd0);
        check("rst_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_valid", {31'd0, u_if.gain_valid}, 32'd0);
        check("rst_overrun", {31'd0, u_if.overrun}, 32'd0);

        set_env(0, 0, 32'd1000, 32'd2);
        set_env(0, 1, -32'sd500, 32'd2);
        set_env(0, 2, 32'd0, 32'd0);
        set_env(1, 0, 32'h7000_0000, 32'd5);
        set_env(1, 1, 32'd0, 32'd0);
        set_env(1, 2, 32'd0, 32'd0);
        set_env(2, 0, 32'd5, 32'd1);
        set_env(2, 1, -32'sd10, 32'd3);
        set_env(2, 2, 32'd0, 32'd0);
        set_env(3, 0, 32'd7, 32'd1);
        set_env(3, 1, 32'd0, 32'd0);
        set_env(3, 2, 32'd0, 32'd0);

        set_vec(0, 4'b0000, 32'd0,    32'd0,         32'd0, 32'd0, 4'b0000);
        set_vec(1, 4'b1111, 32'd0,    32'd0,         32'd0, 32'd0, 4'b1111);
        set_vec(2, 4'b0000, 32'd1000, 32'h7000_0000, 32'd5, 32'd7, 4'b1111);
        set_vec(3, 4'b0000, 32'd2000, 32'h7FFF_FFFF, 32'd0, 32'd7, 4'b1111);
        set_vec(4, 4'b0000, 32'd1500, 32'h7FFF_FFFF, 32'd0, 32'd7, 4'b0111);
        set_vec(5, 4'b0000, 32'd1000, 32'h7FFF_FFFF, 32'd0, 32'd7, 4'b0111);
        set_vec(6, 4'b0000, 32'd1000, 32'h7FFF_FFFF, 32'd0, 32'd7, 4'b0010);
        set_vec(7, 4'b0000, 32'd1000, 32'h7FFF_FFFF, 32'd0, 32'd7, 4'b0010);
        set_vec(8, 4'b0000, 32'd1000, 32'h7FFF_FFFF, 32'd0, 32'd7, 4'b0000);
        set_vec(9, 4'b0010, 32'd1000, 32'd0,         32'd0, 32'd7, 4'b0010);

        for (int k = 0; k < 10; k++) begin
            run_pass(vecs[k].note, lat);
            check($sformatf("vec%0d_latency", k), lat, 32'd5);
            for (int i = 0; i < N_OSC; i++)
                check($sformatf("vec%0d_gain%0d", k, i), u_if.gain[i], vecs[k].g[i]);
            check($sformatf("vec%0d_active", k), {28'd0, u_if.active}, {28'd0, vecs[k].act});
            step();
            check($sformatf("vec%0d_valid_pulse", k), {31'd0, u_if.gain_valid}, 32'd0);
        end
        check("pre_b2b_overrun", {31'd0, u_if.overrun}, 32'd0);

        // Back-to-back ticks: second one lands in RUN and must be dropped.
        step();
        u_if.sample_tick = 1'b1;
        lat = 0;
        step();
        u_if.sample_tick = 1'b0;
        lat = 1;
        step();
        u_if.sample_tick = 1'b1;
        lat = 2;
        step();
        u_if.sample_tick = 1'b0;
        lat = 3;
        check("b2b_overrun", {31'd0, u_if.overrun}, 32'd1);
        check("b2b_busy", {31'd0, u_if.busy}, 32'd1);
        while (!u_if.gain_valid && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_latency", lat, 32'd5);
        step();
        check("b2b_no_second_pass", {31'd0, u_if.busy}, 32'd0);
        run_pass('0, lat);
        check("b2b_next_latency", lat, 32'd5);
        check("b2b_overrun_sticky", {31'd0, u_if.overrun}, 32'd1);

        // note_on[3] arriving in the very cycle osc3 is processed.
        step();
        u_if.sample_tick = 1'b1;
        step();
        u_if.sample_tick = 1'b0;
        step();
        step();
        step();
        u_if.note_on = 4'b1000;
        step();
        u_if.note_on = '0;
        check("coll_valid", {31'd0, u_if.gain_valid}, 32'd1);
        check("coll_gain3_same_pass", u_if.gain[3], 32'd7);
        check("coll_active3_same_pass", {31'd0, u_if.active[3]}, 32'd0);
        run_pass('0, lat);
        check("coll_latency", lat, 32'd5);
        check("coll_gain3_next_pass", u_if.gain[3], 32'd0);
        check("coll_active3_next_pass", {31'd0, u_if.active[3]}, 32'd1);

        // Reset in cycle 3 of a pass.
        step();
        u_if.sample_tick = 1'b1;
        step();
        u_if.sample_tick = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mrst_gain0", u_if.gain[0], 32'd0);
        check("mrst_active", {28'd0, u_if.active}, 32'd0);
        check("mrst_busy", {31'd0, u_if.busy}, 32'd0);
        check("mrst_overrun", {31'd0, u_if.overrun}, 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 1) rst = 1'b0;
            if (u_if.gain_valid) seen = 1;
        end
        check("mrst_no_valid", seen, 32'd0);
        run_pass('0, lat);
        check("mrst_full_pass_latency", lat, 32'd5);
        check("mrst_gain0_after", u_if.gain[0], 32'd0);

        // Randomized passes against the reference model.
        model_reset();
        for (int p = 0; p < 40; p++) begin
            for (int o = 0; o < N_OSC; o++) begin
                for (int s = 0; s < ENV_LEN; s++) begin
                    case ($urandom_range(0, 3))
                        0: rv = 32'($urandom_range(0, 100)) - 32'd50;
                        1: rv = {1'b0, 31'($urandom)};
                        2: rv = {1'b1, 31'($urandom)};
                        default: rv = 32'd0;
                    endcase
                    set_env(o, s, rv, 32'($urandom_range(0, 3)));
                end
            end
            note = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            for (int i = 0; i < N_OSC; i++)
                if (note[i]) m_pend[i] = 1'b1;
            model_pass();
            run_pass(note, lat);
            check($sformatf("rnd%0d_latency", p), lat, 32'd5);
            for (int i = 0; i < N_OSC; i++) begin
                check($sformatf("rnd%0d_gain%0d", p, i), u_if.gain[i], 32'(m_gain[i]));
                check($sformatf("rnd%0d_active%0d", p, i), {31'd0, u_if.active[i]},
                      {31'd0, m_stage[i] != ENV_LEN});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/envelope_scheduler.md
Name: envelope_scheduler

Overview:
- Time-multiplexes one envelope-update datapath across all oscillators.
- On each sample tick, walks oscillators 0..N_OSC-1, one per clock, advancing each through its (rate, duration) stages taken from the MCU-written synth_t configuration.
- Produces per-oscillator gain words for the wavegen/mixer stage, plus a one-cycle valid strobe when the pass completes.

Parameters:
- N_OSC, `N_OSCILLATORS, number of oscillators scheduled.
- ENV_LEN, `ENVELOPE_LEN, envelope stages per oscillator.
- GAIN_MAX, 32'h7FFF_FFFF, upper saturation bound for gain.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- sample_tick  input  1  one-cycle pulse that starts an update pass.
- synth  input  synth_t  live configuration; only wave_gens[i].envelopes is used.
- note_on  input  N_OSC  per-oscillator restart pulse.
- gain  output  N_OSC x 32  registered current gain per oscillator, unsigned.
- active  output  N_OSC  1 while the oscillator's stage < ENV_LEN.
- gain_valid  output  1  one-cycle pulse when a pass finishes.
- busy  output  1  high during RUN and DONE.
- overrun  output  1  sticky; set when sample_tick arrives while busy.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - gain = 0, stage = ENV_LEN, elapsed = 0, pending = 0, therefore active = 0.
  - FSM = IDLE; gain_valid, busy and overrun all 0.
  - Reset asserted mid-pass aborts the pass; no gain_valid is issued.
- Per-oscillator state: stage (clog2(ENV_LEN+1) bits), elapsed (32 bits), gain (32 bits), pending (1 bit).
- FSM states:
  - IDLE: sample_tick -> RUN with idx = 0.
  - RUN: processes oscillator idx this cycle; idx increments; after idx = N_OSC-1 -> DONE.
  - DONE: gain_valid = 1 for exactly one cycle -> IDLE.
- Latency:
  - sample_tick in cycle 0 -> oscillator i updated at the edge ending cycle 1+i.
  - gain_valid high in cycle N_OSC+1.
  - Next tick is accepted from cycle N_OSC+2.
- Overrun: sample_tick while busy is ignored and sets overrun. overrun is cleared only by reset.
- note_on:
  - note_on[i] sets pending[i].
  - If note_on[i] arrives in the same cycle oscillator i is processed, pending[i] stays 1 (set wins) and is applied on the next pass.
- Update rule for oscillator i (rate r = envelopes[stage].rate as signed 32-bit, d = envelopes[stage].duration as unsigned), in priority order:
  1. pending[i]: stage = 0, elapsed = 0, gain = 0, pending = 0. No rate is applied this pass.
  2. stage == ENV_LEN: hold all state.
  3. d == 0: stage += 1, elapsed = 0, gain unchanged. Only one stage advance per pass.
  4. Otherwise: gain = sat(gain + r); elapsed += 1. If elapsed+1 == d: stage += 1, elapsed = 0.
- Arithmetic:
  - Sum is computed 33-bit signed.
  - Result < 0 -> 0; result > GAIN_MAX -> GAIN_MAX.
- Configuration: synth is sampled combinationally in the cycle the oscillator is processed. A mid-pass MCU update affects only oscillators not yet processed.
- active[i] = (stage[i] != ENV_LEN), registered alongside gain.

Decomposition:
- Shared package (protocol_pkg or a new envelope_pkg): env_state_t {stage, elapsed, gain} and sched_state_e {IDLE, RUN, DONE}.
- Shared constant: GAIN_MAX.
- Sub-module envelope_step: purely combinational.
  - Inputs: env_state_t, pending, envelope_t array of one wavegen.
  - Output: next env_state_t.
  - One instance, muxed by idx; this is the shared datapath.

Test Plan (N_OSC=4, ENV_LEN=3):
- Reset then idle: gain all 0, active = 4'b0000. A tick produces gain_valid exactly 5 cycles after the tick and leaves gains unchanged.
- Osc0 envelopes {(1000,2),(-500,2),(0,0)}, note_on[0], then ticks:
  - Tick 1 restarts (gain 0).
  - Ticks 2..6 give gain 1000, 2000, 1500, 1000, 1000.
  - active[0] falls after tick 6.
- Saturation:
  - Osc1 rate 32'h7000_0000, dur 5: gain reaches 32'h7FFF_FFFF on tick 3 and holds.
  - Osc2 rate -10 from gain 5: clamps to 0.
- Back-to-back ticks: tick in cycle 0 and cycle 2 -> second tick is ignored, overrun = 1 and stays 1 until rst; first pass completes normally.
- note_on[3] pulsed in the cycle osc3 is processed: not applied that pass, applied on the next pass (gain[3] = 0, active[3] = 1).
- Reset asserted in cycle 3 of a pass: all outputs 0 asynchronously, no gain_valid. A new tick after release runs a full pass.
